// File: rtl/budget_dispatcher.sv
// budget_dispatcher
// Per-queue bandwidth regulation and single-grant sequencing between the
// request FIFOs, the queue-selection policy and the shared memory port.
// Optional statistics (grant_count, throttle_events) are built only when
// DISPATCHER_STATS_EN is defined.
module budget_dispatcher #(
   parameter int NUMBER_OF_QUEUES = 4,
   parameter int BUDGET_SIZE      = 16,
   parameter int PERIOD_SIZE      = 32
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic [NUMBER_OF_QUEUES-1:0]              empty,
   output logic [NUMBER_OF_QUEUES-1:0]              masked_empty,
   input  logic                                     policy_valid,
   input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]      policy_selection,
   output logic                                     policy_update,
   output logic [NUMBER_OF_QUEUES-1:0]              pop,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [$clog2(NUMBER_OF_QUEUES)-1:0]      out_queue,
   input  logic                                     cfg_load,
   input  logic [NUMBER_OF_QUEUES*BUDGET_SIZE-1:0]  budget_cfg,
   input  logic [PERIOD_SIZE-1:0]                   period_cfg,
   output logic [NUMBER_OF_QUEUES-1:0]              throttled
`ifdef DISPATCHER_STATS_EN
  ,output logic [NUMBER_OF_QUEUES*32-1:0]           grant_count,
   output logic [NUMBER_OF_QUEUES*16-1:0]           throttle_events
`endif
);

   localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);
   localparam logic [BUDGET_SIZE-1:0] BUDGET_ZERO = {BUDGET_SIZE{1'b0}};
   localparam logic [BUDGET_SIZE-1:0] BUDGET_ONE  = {{(BUDGET_SIZE-1){1'b0}}, 1'b1};
   localparam logic [PERIOD_SIZE-1:0] PERIOD_ZERO = {PERIOD_SIZE{1'b0}};
   localparam logic [PERIOD_SIZE-1:0] PERIOD_ONE  = {{(PERIOD_SIZE-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      ISSUE   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                  state;
   logic [BUDGET_SIZE-1:0]  budget_active [NUMBER_OF_QUEUES];
   logic [BUDGET_SIZE-1:0]  remaining     [NUMBER_OF_QUEUES];
   logic [PERIOD_SIZE-1:0]  period_active;
   logic [PERIOD_SIZE-1:0]  period_count;

   logic                        regulation_on;
   logic                        wrap;
   logic                        handshake;
   logic                        selection_ok;
   logic [NUMBER_OF_QUEUES-1:0] grant_onehot;

   // Throttle masking, grant decode and policy-choice qualification.
   always_comb begin
      regulation_on = (period_active != PERIOD_ZERO);
      wrap          = regulation_on && (period_count == (period_active - PERIOD_ONE));
      handshake     = out_valid && out_ready;
      selection_ok  = 1'b0;
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
         throttled[q]    = regulation_on && (remaining[q] == BUDGET_ZERO);
         grant_onehot[q] = handshake && (out_queue == SEL_W'(q));
      end
      masked_empty = empty | throttled;
      for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
         if ((policy_selection == SEL_W'(q)) && !masked_empty[q]) begin
            selection_ok = policy_valid;
         end else begin
            selection_ok = selection_ok;
         end
      end
      pop           = grant_onehot;
      policy_update = handshake;
   end

   // Grant sequencer: IDLE -> SETTLE -> ISSUE (hold offer until accepted) -> RELEASE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_queue <= {SEL_W{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (~&masked_empty) begin
                  state <= SETTLE;
               end else begin
                  state <= IDLE;
               end
            end
            SETTLE: begin
               if (selection_ok) begin
                  state     <= ISSUE;
                  out_valid <= 1'b1;
                  out_queue <= policy_selection;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               if (out_ready) begin
                  state     <= RELEASE;
                  out_valid <= 1'b0;
               end else begin
                  state <= ISSUE;
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Budget configuration, period counter and per-queue remaining-grant counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         period_active <= PERIOD_ZERO;
         period_count  <= PERIOD_ZERO;
         for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            budget_active[q] <= BUDGET_ZERO;
            remaining[q]     <= BUDGET_ZERO;
         end
      end else if (cfg_load) begin
         period_active <= period_cfg;
         period_count  <= PERIOD_ZERO;
         for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            budget_active[q] <= budget_cfg[q*BUDGET_SIZE +: BUDGET_SIZE];
            remaining[q]     <= budget_cfg[q*BUDGET_SIZE +: BUDGET_SIZE];
         end
      end else begin
         if (wrap || !regulation_on) begin
            period_count <= PERIOD_ZERO;
         end else begin
            period_count <= period_count + PERIOD_ONE;
         end
         for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            if (wrap) begin
               // A grant landing on the replenish cycle is charged to the new period.
               if (grant_onehot[q] && (budget_active[q] != BUDGET_ZERO)) begin
                  remaining[q] <= budget_active[q] - BUDGET_ONE;
               end else begin
                  remaining[q] <= budget_active[q];
               end
            end else if (grant_onehot[q] && regulation_on && (remaining[q] != BUDGET_ZERO)) begin
               remaining[q] <= remaining[q] - BUDGET_ONE;
            end else begin
               remaining[q] <= remaining[q];
            end
         end
      end
   end

`ifdef DISPATCHER_STATS_EN
   logic [NUMBER_OF_QUEUES-1:0] throttled_prev;

   // Per-queue accepted-grant counters and throttle rising-edge counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         grant_count     <= {(NUMBER_OF_QUEUES*32){1'b0}};
         throttle_events <= {(NUMBER_OF_QUEUES*16){1'b0}};
         throttled_prev  <= {NUMBER_OF_QUEUES{1'b0}};
      end else if (cfg_load) begin
         grant_count     <= {(NUMBER_OF_QUEUES*32){1'b0}};
         throttle_events <= {(NUMBER_OF_QUEUES*16){1'b0}};
         throttled_prev  <= throttled;
      end else begin
         throttled_prev <= throttled;
         for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
            if (grant_onehot[q]) begin
               grant_count[q*32 +: 32] <= grant_count[q*32 +: 32] + 32'd1;
            end else begin
               grant_count[q*32 +: 32] <= grant_count[q*32 +: 32];
            end
            if (throttled[q] && !throttled_prev[q]) begin
               throttle_events[q*16 +: 16] <= throttle_events[q*16 +: 16] + 16'd1;
            end else begin
               throttle_events[q*16 +: 16] <= throttle_events[q*16 +: 16];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_budget_dispatcher.sv
// Self-checking bench for budget_dispatcher: a grant-level reference model
// (budgets, period position, grant slot) compared every cycle, directed
// scenarios pinned with hand-computed literals, then randomized traffic.
module tb_budget_dispatcher;

   localparam int N = 4;
   localparam int B = 16;
   localparam int P = 32;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   empty;
   logic [N-1:0]   masked_empty;
   logic           policy_valid;
   logic [1:0]     policy_selection;
   logic           policy_update;
   logic [N-1:0]   pop;
   logic           out_valid;
   logic           out_ready;
   logic [1:0]     out_queue;
   logic           cfg_load;
   logic [N*B-1:0] budget_cfg;
   logic [P-1:0]   period_cfg;
   logic [N-1:0]   throttled;
`ifdef DISPATCHER_STATS_EN
   logic [N*32-1:0] grant_count;
   logic [N*16-1:0] throttle_events;
`endif

   always #5 clock = ~clock;

   budget_dispatcher #(.NUMBER_OF_QUEUES(N), .BUDGET_SIZE(B), .PERIOD_SIZE(P)) dut (
      .clock(clock), .reset(reset), .empty(empty), .masked_empty(masked_empty),
      .policy_valid(policy_valid), .policy_selection(policy_selection),
      .policy_update(policy_update), .pop(pop), .out_valid(out_valid),
      .out_ready(out_ready), .out_queue(out_queue), .cfg_load(cfg_load),
      .budget_cfg(budget_cfg), .period_cfg(period_cfg), .throttled(throttled)
`ifdef DISPATCHER_STATS_EN
     ,.grant_count(grant_count), .throttle_events(throttle_events)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cycle_no = 0;

   // reference model state: slot 0 idle, 1 settle, 2 offering, 3 release
   int m_rem [N];
   int m_bud [N];
   int m_period, m_pcount, m_slot, m_q;
   logic [N-1:0] m_thr, m_masked, m_pop, hist;
   logic m_ov, m_upd;

   int pop_cnt [N];
   int first_valid, last_pop;
   logic [N-1:0] pop_or;
   bit noise = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cycle_no);
      end
   endtask

   function automatic void model_comb();
      bit reg_on;
      reg_on = (m_period != 0);
      for (int q = 0; q < N; q++) m_thr[q] = reg_on && (m_rem[q] == 0);
      m_masked = empty | m_thr;
      m_ov  = (m_slot == 2);
      m_upd = m_ov && out_ready;
      m_pop = m_upd ? (4'b0001 << m_q) : 4'b0000;
   endfunction

   function automatic void model_seq();
      bit reg_on, wrap, grant;
      int dec;
      if (reset) begin
         for (int q = 0; q < N; q++) begin m_rem[q] = 0; m_bud[q] = 0; end
         m_period = 0; m_pcount = 0; m_slot = 0; m_q = 0;
         return;
      end
      reg_on = (m_period != 0);
      grant  = (m_slot == 2) && out_ready;
      if (cfg_load) begin
         for (int q = 0; q < N; q++) begin
            m_bud[q] = int'(budget_cfg[q*B +: B]);
            m_rem[q] = m_bud[q];
         end
         m_period = int'(period_cfg);
         m_pcount = 0;
      end else begin
         wrap = reg_on && (m_pcount == m_period - 1);
         for (int q = 0; q < N; q++) begin
            dec = (grant && reg_on && m_q == q) ? 1 : 0;
            if (wrap) m_rem[q] = (m_bud[q] - dec < 0) ? 0 : m_bud[q] - dec;
            else      m_rem[q] = (m_rem[q] - dec < 0) ? 0 : m_rem[q] - dec;
         end
         m_pcount = wrap ? 0 : m_pcount + 1;
      end
      case (m_slot)
         0: if (m_masked != 4'b1111) m_slot = 1;
         1: if (policy_valid && !m_masked[policy_selection]) begin
               m_slot = 2; m_q = int'(policy_selection);
            end else m_slot = 0;
         2: if (out_ready) m_slot = 3;
         default: m_slot = 0;
      endcase
   endfunction

   task automatic compare();
      check("masked_empty", masked_empty, m_masked);
      check("throttled", throttled, m_thr);
      check("out_valid", out_valid, m_ov);
      if (m_ov) check("out_queue", out_queue, m_q);
      check("pop", pop, m_pop);
      check("policy_update", policy_update, m_upd);
      for (int q = 0; q < N; q++) if (pop[q]) pop_cnt[q]++;
      if (pop != 4'b0000) last_pop = cycle_no;
      pop_or = pop_or | pop;
      if (out_valid && first_valid < 0) first_valid = cycle_no;
   endtask

   // one clock: compare current cycle, advance model, then registered policy stub
   task automatic tick();
      #1;
      model_comb();
      compare();
      hist = m_masked;
      @(posedge clock);
      model_seq();
      @(negedge clock);
      if (noise && $urandom_range(0, 9) == 0) begin
         policy_valid     = 1'($urandom_range(0, 1));
         policy_selection = 2'($urandom_range(0, 3));
      end else begin
         policy_valid = (hist != 4'b1111);
         for (int q = N - 1; q >= 0; q--) if (!hist[q]) policy_selection = 2'(q);
      end
      cycle_no++;
   endtask

   task automatic clear_stats();
      for (int q = 0; q < N; q++) pop_cnt[q] = 0;
      first_valid = -1; last_pop = -1; pop_or = 4'b0000;
   endtask

   task automatic do_reset();
      reset = 1'b1; cfg_load = 1'b0; empty = 4'b1111; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_pop", pop, 4'b0000);
      check("rst_update", policy_update, 1'b0);
      check("rst_out_queue", out_queue, 2'd0);
      check("rst_throttled", throttled, 4'b0000);
   endtask

   task automatic load_cfg(input int b3, input int b2, input int b1, input int b0, input int per);
      cfg_load   = 1'b1;
      budget_cfg = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
      period_cfg = 32'(per);
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic wait_offer();
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         tick();
      end
      check("wait_offer", out_valid, 1'b1);
   endtask

   int t0;

   initial begin
      reset = 1'b1; empty = 4'b1111; policy_valid = 1'b0; policy_selection = 2'd0;
      out_ready = 1'b0; cfg_load = 1'b0; budget_cfg = '0; period_cfg = '0; hist = 4'b1111;
      clear_stats();
      @(posedge clock); model_seq(); @(negedge clock);
      do_reset();

      // A: unregulated, queue 0 only, always ready: offers 2 cycles in, grants every 4
      tick(); tick();
      empty = 4'b1110; out_ready = 1'b1; clear_stats(); t0 = cycle_no;
      repeat (20) tick();
      check("A_first_valid", first_valid, t0 + 2);
      check("A_grants_q0", pop_cnt[0], 5);
      check("A_last_pop", last_pop, t0 + 18);
      check("A_pop_pattern", pop_or, 4'b0001);

      // B: period 100, budget 2, queue 1 busy
      do_reset();
      load_cfg(2, 2, 2, 2, 100);
      empty = 4'b1101; out_ready = 1'b1; clear_stats();
      repeat (99) tick();
      check("B_grants_p1", pop_cnt[1], 2);
      check("B_throttled", throttled, 4'b0010);
      check("B_masked", masked_empty, 4'b1111);
      repeat (100) tick();
      check("B_grants_p2", pop_cnt[1], 4);

      // C: backpressure holds the offer, single pop on accept
      do_reset();
      empty = 4'b1011; out_ready = 1'b0; clear_stats();
      wait_offer();
      repeat (10) begin
         check("C_hold_valid", out_valid, 1'b1);
         check("C_hold_queue", out_queue, 2'd2);
         check("C_hold_pop", pop, 4'b0000);
         tick();
      end
      out_ready = 1'b1; #1;
      check("C_accept_pop", pop, 4'b0100);
      check("C_accept_update", policy_update, 1'b1);
      tick();
      check("C_release_valid", out_valid, 1'b0);
      out_ready = 1'b0;
      tick(); tick(); tick();
      check("C_pop_count", pop_cnt[2], 1);

      // D: grant coincident with period wrap, budget 3 -> 2 left for the new period
      do_reset();
      load_cfg(3, 3, 3, 3, 20);
      empty = 4'b1110; out_ready = 1'b0;
      repeat (19) tick();
      check("D_offer_at_wrap", out_valid, 1'b1);
      out_ready = 1'b1; clear_stats();
      repeat (18) tick();
      check("D_grants", pop_cnt[0], 3);
      check("D_throttled", throttled, 4'b0001);

      // E: zero budget with regulation on -> queue 2 never served
      do_reset();
      load_cfg(5, 0, 5, 5, 50);
      empty = 4'b1011; out_ready = 1'b1; clear_stats();
      repeat (120) begin
         check("E_thr2", throttled[2], 1'b1);
         tick();
      end
      check("E_pops", pop_cnt[2], 0);
      check("E_no_offer", first_valid, -1);

      // F: reset while offering drops the offer and clears budgets
      do_reset();
      load_cfg(4, 4, 4, 4, 30);
      empty = 4'b1110; out_ready = 1'b0; clear_stats();
      wait_offer();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("F_valid", out_valid, 1'b0);
      check("F_pop", pop, 4'b0000);
      check("F_throttled", throttled, 4'b0000);
      check("F_pops", pop_cnt[0], 0);

      // R: randomized traffic, config reloads and resets against the model
      noise = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 199) == 0);
         cfg_load = ($urandom_range(0, 49) == 0);
         if (cfg_load) begin
            for (int q = 0; q < N; q++) budget_cfg[q*B +: B] = 16'($urandom_range(0, 3));
            period_cfg = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
         end
         empty     = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      noise = 1'b0;
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
